// File: rtl/mm_pkg.sv
// Shared state encoding and sizing helpers for the matrix max scanner.
package mm_pkg;
  localparam int DATA_W_DEF  = 4;
  localparam int MAT_DIM_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int elem_count(input int mat_dim);
    return mat_dim * mat_dim;
  endfunction

  function automatic int idx_w(input int mat_dim);
    return $clog2(mat_dim);
  endfunction

  function automatic int cnt_w(input int mat_dim);
    return $clog2(mat_dim * mat_dim);
  endfunction
endpackage

// File: rtl/mm_gt_compare.sv
// Strict unsigned greater-than; the single comparator shared by every element of a scan.
module mm_gt_compare #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt
);
  assign gt = (a > b);
endmodule

// File: rtl/matrix_max_scanner.sv
// Streams one MAT_DIM x MAT_DIM matrix in row-major order and reports the
// maximum element and the (row, col) of its first occurrence.
module matrix_max_scanner
  import mm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAT_DIM = MAT_DIM_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      result_valid,
  output logic [DATA_W-1:0]         max_val,
  output logic [idx_w(MAT_DIM)-1:0] max_row,
  output logic [idx_w(MAT_DIM)-1:0] max_col
);
  localparam int N     = elem_count(MAT_DIM);
  localparam int IDX_W = idx_w(MAT_DIM);
  localparam int CNT_W = cnt_w(MAT_DIM);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_run_max, w_run_max_next;
  logic [CNT_W-1:0]    r_run_idx, w_run_idx_next;
  logic                r_busy, r_done, r_result_valid;
  logic [DATA_W-1:0]   r_max_val;
  logic [IDX_W-1:0]    r_max_row, r_max_col;
  logic                w_accept, w_last, w_gt, w_take;

  mm_gt_compare #(.DATA_W(DATA_W)) u_gt (
    .a  (in_data),
    .b  (r_run_max),
    .gt (w_gt)
  );

  assign in_ready = (r_state == ST_SCAN);
  // abort discards the element offered in the same cycle, including the last one
  assign w_accept = in_valid & in_ready & ~abort;
  assign w_last   = w_accept & (r_count == CNT_W'(N - 1));
  assign w_take   = w_accept & ((r_count == '0) | w_gt);

  assign w_run_max_next = w_take ? in_data : r_run_max;
  assign w_run_idx_next = w_take ? r_count : r_run_idx;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_SCAN;
      ST_SCAN: begin
        if (abort)       w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count        <= '0;
      r_run_max      <= '0;
      r_run_idx      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_max_val      <= '0;
      r_max_row      <= '0;
      r_max_col      <= '0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (r_state == ST_SCAN) && (w_state_next == ST_DONE);
      if ((r_state == ST_IDLE) && start) begin
        r_count        <= '0;
        r_result_valid <= 1'b0;
      end
      if ((r_state == ST_SCAN) && abort)
        r_result_valid <= 1'b0;
      if (w_accept)
        r_count <= r_count + CNT_W'(1);
      if (w_take) begin
        r_run_max <= in_data;
        r_run_idx <= r_count;
      end
      // results take the post-update running values so they move with done
      if (w_last) begin
        r_max_val      <= w_run_max_next;
        r_max_row      <= IDX_W'(w_run_idx_next / CNT_W'(MAT_DIM));
        r_max_col      <= IDX_W'(w_run_idx_next % CNT_W'(MAT_DIM));
        r_result_valid <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;
  assign max_val      = r_max_val;
  assign max_row      = r_max_row;
  assign max_col      = r_max_col;
endmodule
